// File: rtl/dsp48e2_alu_pkg.sv
// Shared definitions for the DSP48E2-style ALU slice: opmode field layout,
// mux select codes, alumode encodings and SIMD lane widths.
// Optional multiplier is enabled by defining DSP48E2_ALU_MULT_EN.
package dsp48e2_alu_pkg;

  localparam int DATA_W = 48;

  // SIMD lane widths for the three adder splits
  localparam int LANE_W_ONE48  = 48;
  localparam int LANE_W_TWO24  = 24;
  localparam int LANE_W_FOUR12 = 12;

  // opmode layout: W=[8:7], Z=[6:4], Y=[3:2], X=[1:0]
  typedef struct packed {
    logic [1:0] w;
    logic [2:0] z;
    logic [1:0] y;
    logic [1:0] x;
  } opmode_t;

  // X mux selects
  localparam logic [1:0] X_ZERO = 2'b00;
  localparam logic [1:0] X_M    = 2'b01;
  localparam logic [1:0] X_P    = 2'b10;
  localparam logic [1:0] X_AB   = 2'b11;

  // Y mux selects
  localparam logic [1:0] Y_ZERO = 2'b00;
  localparam logic [1:0] Y_M    = 2'b01;
  localparam logic [1:0] Y_ONES = 2'b10;
  localparam logic [1:0] Y_C    = 2'b11;

  // Z mux selects (every other code yields zero)
  localparam logic [2:0] Z_ZERO = 3'b000;
  localparam logic [2:0] Z_P    = 3'b010;
  localparam logic [2:0] Z_C    = 3'b011;

  // W mux selects
  localparam logic [1:0] W_ZERO = 2'b00;
  localparam logic [1:0] W_P    = 2'b01;
  localparam logic [1:0] W_NONE = 2'b10;
  localparam logic [1:0] W_C    = 2'b11;

  // alumode encodings; anything unlisted behaves as ALU_ADD
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b1100;

endpackage

// File: rtl/dsp48e2_alu_simd_adder.sv
// Lane-split four-operand adder/subtractor. Each lane computes
// Z + (W+X+Y+CIN) or Z - (W+X+Y+CIN) on its own bits only, so no carry
// ever crosses a lane boundary. carryin feeds lane 0 only.
// Lane carry-out: any overflow of the lane for add, "no borrow" for subtract.
module dsp48e2_simd_adder
  import dsp48e2_alu_pkg::*;
#(
  parameter int LANE_W = 48
) (
  input  logic [DATA_W-1:0] z,
  input  logic [DATA_W-1:0] w,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  input  logic              cin,
  input  logic              sub,
  output logic [DATA_W-1:0] sum,
  output logic [3:0]        cout
);

  localparam int LANES = DATA_W / LANE_W;
  localparam int CO_STEP = 4 / LANES;

  logic [LANES-1:0] w_lane_co;
  logic [3:0]       w_cin_vec;

  assign w_cin_vec = {3'b000, cin};

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam int LSB = i * LANE_W;
    logic [LANE_W+1:0] w_rhs;
    logic [LANE_W+2:0] w_add;
    logic [LANE_W+2:0] w_diff;

    // Right-hand operand sum is kept two bits wider so it never wraps
    assign w_rhs  = (LANE_W+2)'(x[LSB +: LANE_W]) + (LANE_W+2)'(y[LSB +: LANE_W])
                  + (LANE_W+2)'(w[LSB +: LANE_W]) + (LANE_W+2)'(w_cin_vec[i]);
    assign w_add  = (LANE_W+3)'(z[LSB +: LANE_W]) + (LANE_W+3)'(w_rhs);
    assign w_diff = (LANE_W+3)'(z[LSB +: LANE_W]) - (LANE_W+3)'(w_rhs);

    assign sum[LSB +: LANE_W] = sub ? w_diff[LANE_W-1:0] : w_add[LANE_W-1:0];
    assign w_lane_co[i]       = sub ? ~w_diff[LANE_W+2] : (|w_add[LANE_W+2:LANE_W]);
  end

  // Route each lane's carry to the top carryout bit of its 12-bit slot; the rest stay 0
  always_comb begin
    cout = '0;
    for (int i = 0; i < LANES; i++) begin
      cout[(i+1)*CO_STEP-1] = w_lane_co[i];
    end
  end

endmodule

// File: rtl/dsp48e2_alu.sv
// DSP48E2-style ALU: W/X/Y/Z operand muxes, SIMD add/sub, XOR/AND, optional
// C and P pipeline registers. Define DSP48E2_ALU_MULT_EN to include the
// 27x18 signed multiplier feeding M; otherwise M is constant zero.
module dsp48e2_alu
  import dsp48e2_alu_pkg::*;
#(
  parameter string USE_SIMD = "ONE48",
  parameter int    PREG     = 1,
  parameter int    CREG     = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cep,
  input  logic              cec,
  input  logic [3:0]        alumode,
  input  logic [8:0]        opmode,
  input  logic [29:0]       a,
  input  logic [17:0]       b,
  input  logic [47:0]       c,
  input  logic              carryin,
  output logic [47:0]       p,
  output logic [3:0]        carryout
);

  localparam int LANE_W = (USE_SIMD == "FOUR12") ? LANE_W_FOUR12 :
                          (USE_SIMD == "TWO24")  ? LANE_W_TWO24  : LANE_W_ONE48;

  opmode_t           w_op;
  logic [DATA_W-1:0] w_c;
  logic [DATA_W-1:0] w_m;
  logic [DATA_W-1:0] w_pfb;
  logic [DATA_W-1:0] w_x;
  logic [DATA_W-1:0] w_y;
  logic [DATA_W-1:0] w_z;
  logic [DATA_W-1:0] w_w;
  logic [DATA_W-1:0] w_sum;
  logic [3:0]        w_sum_co;
  logic [DATA_W-1:0] w_alu_p;
  logic [3:0]        w_alu_co;
  logic              w_sel_m;
  logic              w_unused_ok;

  assign w_op    = opmode_t'(opmode);
  assign w_sel_m = (w_op.x == X_M) && (w_op.y == Y_M);

  // Enables are only consumed when the matching register is configured in
  assign w_unused_ok = &{1'b0, cep, cec};

`ifdef DSP48E2_ALU_MULT_EN
  // Multiplier result is only meaningful with USE_SIMD = "ONE48"
  logic signed [44:0] w_prod;
  assign w_prod = $signed(a[26:0]) * $signed(b[17:0]);
  assign w_m    = {{3{w_prod[44]}}, w_prod};
`else
  assign w_m = '0;
`endif

  // Optional C pipeline register
  if (CREG != 0) begin : g_creg
    logic [DATA_W-1:0] r_c;
    // C register: reset wins over cec
    always_ff @(posedge clock) begin
      if (reset)    r_c <= '0;
      else if (cec) r_c <= c;
    end
    assign w_c = r_c;
  end else begin : g_cdirect
    assign w_c = c;
  end

  // Operand muxes; M enters through X only when X and Y both select it
  always_comb begin
    w_x = '0;
    w_y = '0;
    w_z = '0;
    w_w = '0;
    case (w_op.x)
      X_M:     w_x = w_sel_m ? w_m : '0;
      X_P:     w_x = w_pfb;
      X_AB:    w_x = {a, b};
      default: w_x = '0;
    endcase
    case (w_op.y)
      Y_ONES:  w_y = '1;
      Y_C:     w_y = w_c;
      default: w_y = '0;
    endcase
    case (w_op.z)
      Z_P:     w_z = w_pfb;
      Z_C:     w_z = w_c;
      default: w_z = '0;
    endcase
    case (w_op.w)
      W_P:     w_w = w_pfb;
      W_C:     w_w = w_c;
      default: w_w = '0;
    endcase
  end

  dsp48e2_simd_adder #(
    .LANE_W (LANE_W)
  ) u_adder (
    .z    (w_z),
    .w    (w_w),
    .x    (w_x),
    .y    (w_y),
    .cin  (carryin),
    .sub  (alumode == ALU_SUB),
    .sum  (w_sum),
    .cout (w_sum_co)
  );

  // Result select: logic ops bypass the adder and report no carry
  always_comb begin
    w_alu_p  = w_sum;
    w_alu_co = w_sum_co;
    case (alumode)
      ALU_XOR: begin
        w_alu_p  = w_x ^ w_z;
        w_alu_co = '0;
      end
      ALU_AND: begin
        w_alu_p  = w_x & w_z;
        w_alu_co = '0;
      end
      default: begin
        w_alu_p  = w_sum;
        w_alu_co = w_sum_co;
      end
    endcase
  end

  // Optional P pipeline register; feedback is zero when P is combinational
  if (PREG != 0) begin : g_preg
    logic [DATA_W-1:0] r_p;
    logic [3:0]        r_co;
    // P/carryout register: reset wins over cep
    always_ff @(posedge clock) begin
      if (reset) begin
        r_p  <= '0;
        r_co <= '0;
      end else if (cep) begin
        r_p  <= w_alu_p;
        r_co <= w_alu_co;
      end
    end
    assign p        = r_p;
    assign carryout = r_co;
    assign w_pfb    = r_p;
  end else begin : g_pcomb
    assign p        = w_alu_p;
    assign carryout = w_alu_co;
    assign w_pfb    = '0;
  end

endmodule

// File: tb/tb_dsp48e2_alu.sv
// Bench for dsp48e2_alu: three instances share stimulus
//   u_d0: TWO24,  PREG=0, CREG=0
//   u_d1: ONE48,  PREG=1, CREG=0
//   u_d2: FOUR12, PREG=0, CREG=1
// Expected values come from a lane-arithmetic reference model plus constants.
module tb_dsp48e2_alu;

  logic        clock = 1'b0;
  logic        reset;
  logic        cep;
  logic        cec;
  logic [3:0]  alumode;
  logic [8:0]  opmode;
  logic [29:0] a;
  logic [17:0] b;
  logic [47:0] c;
  logic        carryin;
  logic [47:0] p0, p1, p2;
  logic [3:0]  co0, co1, co2;

  int n_cmp = 0;
  int n_bad = 0;

  logic [51:0] snap0, snap1, snap2;
  logic [51:0] m_p1;
  logic [47:0] m_c2;

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  dsp48e2_alu #(.USE_SIMD("TWO24"), .PREG(0), .CREG(0)) u_d0 (
    .clock(clock), .reset(reset), .cep(cep), .cec(cec), .alumode(alumode),
    .opmode(opmode), .a(a), .b(b), .c(c), .carryin(carryin),
    .p(p0), .carryout(co0));

  dsp48e2_alu #(.USE_SIMD("ONE48"), .PREG(1), .CREG(0)) u_d1 (
    .clock(clock), .reset(reset), .cep(cep), .cec(cec), .alumode(alumode),
    .opmode(opmode), .a(a), .b(b), .c(c), .carryin(carryin),
    .p(p1), .carryout(co1));

  dsp48e2_alu #(.USE_SIMD("FOUR12"), .PREG(0), .CREG(1)) u_d2 (
    .clock(clock), .reset(reset), .cep(cep), .cec(cec), .alumode(alumode),
    .opmode(opmode), .a(a), .b(b), .c(c), .carryin(carryin),
    .p(p2), .carryout(co2));

  // ---------------- reference model ----------------
  function automatic logic [47:0] mult_ref(input logic [29:0] av, input logic [17:0] bv);
    logic signed [26:0] sa;
    logic signed [17:0] sb;
    logic [63:0]        prod;
    sa   = av[26:0];
    sb   = bv;
    prod = longint'(sa) * longint'(sb);
`ifdef DSP48E2_ALU_MULT_EN
    return prod[47:0];
`else
    return (prod[47:0] & 48'd0);
`endif
  endfunction

  // Returns {carryout, p} for a given lane count, from the mux/ALU rules
  function automatic logic [51:0] ref_model(input int lanes, input logic [3:0] alu,
      input logic [8:0] op, input logic [47:0] ab, input logic [47:0] cc,
      input logic cin, input logic [47:0] pfb, input logic [47:0] m);
    logic [47:0] xv, yv, zv, wv, pr;
    logic [3:0]  co;
    longint      lw, mask, zi, si, d;
    xv = 48'd0; yv = 48'd0; zv = 48'd0; wv = 48'd0;
    case (op[1:0])
      2'b01: xv = (op[3:2] == 2'b01) ? m : 48'd0;
      2'b10: xv = pfb;
      2'b11: xv = ab;
      default: xv = 48'd0;
    endcase
    case (op[3:2])
      2'b10: yv = {48{1'b1}};
      2'b11: yv = cc;
      default: yv = 48'd0;
    endcase
    case (op[6:4])
      3'b010: zv = pfb;
      3'b011: zv = cc;
      default: zv = 48'd0;
    endcase
    case (op[8:7])
      2'b01: wv = pfb;
      2'b11: wv = cc;
      default: wv = 48'd0;
    endcase
    if (alu == 4'b0100) return {4'b0000, xv ^ zv};
    if (alu == 4'b1100) return {4'b0000, xv & zv};
    pr = 48'd0;
    co = 4'b0000;
    lw = 48 / lanes;
    mask = (longint'(1) << lw) - 1;
    for (int i = 0; i < lanes; i++) begin
      zi = longint'({16'd0, zv >> (i*lw)}) & mask;
      si = (longint'({16'd0, wv >> (i*lw)}) & mask) + (longint'({16'd0, xv >> (i*lw)}) & mask)
         + (longint'({16'd0, yv >> (i*lw)}) & mask) + ((i == 0) ? longint'(cin) : 0);
      if (alu == 4'b0011) begin
        d = zi - si;
        co[(i+1)*(4/lanes)-1] = (zi >= si);
      end else begin
        d = zi + si;
        co[(i+1)*(4/lanes)-1] = (d > mask);
      end
      pr = pr | (48'(d & mask) << (i*lw));
    end
    return {co, pr};
  endfunction

  // ---------------- scoreboard / checks ----------------
  task automatic check(input string tag, input logic [51:0] obs, input logic [51:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_ab(input logic [47:0] v);
    a = v[47:18];
    b = v[17:0];
  endtask

  // One clock: check combinational instances mid-cycle, then the registered one after the edge
  task automatic cycle(input bit chk_simd);
    logic [51:0] e;
    logic [51:0] nxt;
    logic [47:0] m;
    m = mult_ref(a, b);
    #3;
    snap0 = {co0, p0};
    snap2 = {co2, p2};
    if (chk_simd) begin
      e = ref_model(2, alumode, opmode, {a, b}, c, carryin, 48'd0, m);
      check("two24_model", snap0, e);
      e = ref_model(4, alumode, opmode, {a, b}, m_c2, carryin, 48'd0, m);
      check("four12_creg_model", snap2, e);
    end
    nxt = ref_model(1, alumode, opmode, {a, b}, c, carryin, m_p1[47:0], m);
    @(posedge clock);
    #1;
    if (reset)    m_p1 = '0;
    else if (cep) m_p1 = nxt;
    if (reset)    m_c2 = '0;
    else if (cec) m_c2 = c;
    snap1 = {co1, p1};
    check("one48_preg_model", snap1, m_p1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    reset = 1'b1; cep = 1'b1; cec = 1'b1;
    alumode = 4'b0000; opmode = 9'd0; a = '0; b = '0; c = '0; carryin = 1'b0;
    m_p1 = '0; m_c2 = '0;
    repeat (2) @(posedge clock);
    #1;

    // reset state and C register timing (Z = C)
    opmode = 9'b00_011_00_00;
    c = 48'h00A_00B_00C_00D;
    cycle(1);
    check("rst_creg", snap2, 52'd0);
    check("rst_preg", snap1, 52'd0);
    reset = 1'b0; cec = 1'b0;
    cycle(1);
    check("creg_hold", snap2, 52'd0);
    check("preg_c_path", snap1, {4'b0000, 48'h00A_00B_00C_00D});
    cec = 1'b1;
    cycle(1);
    check("creg_pre_load", snap2, 52'd0);
    cycle(1);
    check("creg_loaded", snap2, {4'b0000, 48'h00A_00B_00C_00D});

    // TWO24 independent lanes
    alumode = 4'b0000; opmode = 9'b000110011;
    set_ab({24'd3, 24'd1}); c = {24'd4, 24'd2};
    cycle(1);
    check("two24_lanes", snap0, {4'b0000, 24'd7, 24'd3});

    // TWO24 lane-0 wrap without carry into lane 1
    set_ab({24'd5, 24'hFFFFFF}); c = {24'd5, 24'd1};
    cycle(1);
    check("two24_wrap", snap0, {4'b0010, 24'd10, 24'd0});

    // Subtract C - A:B on ONE48 (registered)
    alumode = 4'b0011; c = 48'd10; set_ab(48'd3);
    cycle(1);
    check("one48_sub", snap1, {4'b1000, 48'd7});

    // Accumulate Z=P, X=A:B
    alumode = 4'b0000; opmode = 9'b00_010_00_11; set_ab(48'd1);
    reset = 1'b1;
    cycle(1);
    check("acc_reset", snap1, 52'd0);
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cycle(1);
      check("acc_step", snap1, {4'b0000, 48'(k)});
    end
    cep = 1'b0;
    repeat (2) begin
      cycle(1);
      check("acc_freeze", snap1, {4'b0000, 48'd4});
    end
    reset = 1'b1;
    cycle(1);
    check("acc_reset_over_cep", snap1, 52'd0);

    // Multiplier path: a=-3, b=5
    reset = 1'b0; cep = 1'b1;
    opmode = 9'b000000101; a = 30'h3FFFFFFD; b = 18'd5;
    cycle(0);
`ifdef DSP48E2_ALU_MULT_EN
    check("mult", snap1, {4'b0000, 48'hFFFFFFFFFFF1});
`else
    check("mult_off", snap1, 52'd0);
`endif

    // Randomized stimulus against the reference model
    for (int k = 0; k < 120; k++) begin
      case ($urandom_range(0, 4))
        0: alumode = 4'b0000;
        1: alumode = 4'b0011;
        2: alumode = 4'b0100;
        3: alumode = 4'b1100;
        default: alumode = 4'($urandom_range(0, 15));
      endcase
      opmode = 9'($urandom_range(0, 511));
      if (opmode[1:0] == 2'b01 && opmode[3:2] == 2'b01) opmode[3:2] = 2'b11;
      a       = 30'($urandom);
      b       = 18'($urandom);
      c       = {16'($urandom), 32'($urandom)};
      carryin = 1'($urandom_range(0, 1));
      cep     = ($urandom_range(0, 3) != 0);
      cec     = ($urandom_range(0, 3) != 0);
      reset   = ($urandom_range(0, 19) == 0);
      cycle(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dsp48e2_alu.md
DSP48E2_ALU -- requirements
Module: dsp48e2_alu

Interface
REQ-001 Parameter USE_SIMD, default "ONE48"; adder lane split: "ONE48" (1x48), "TWO24" (2x24), "FOUR12" (4x12).
REQ-002 Parameter PREG, default 1; 0 = P combinational, 1 = P registered.
REQ-003 Parameter CREG, default 0; 0 = C direct, 1 = C registered before the ALU.
REQ-004 clock  input  1  sole clock; all registers update on its rising edge.
REQ-005 reset  input  1  synchronous, active-high; clears all internal registers.
REQ-006 cep  input  1  clock enable for the P register.
REQ-007 cec  input  1  clock enable for the C register.
REQ-008 alumode  input  4  ALU operation select.
REQ-009 opmode  input  9  mux selects: W=[8:7], Z=[6:4], Y=[3:2], X=[1:0].
REQ-010 a  input  30  A data; A:B concatenation and multiplier operand.
REQ-011 b  input  18  B data.
REQ-012 c  input  48  C data.
REQ-013 carryin  input  1  carry into lane 0 only.
REQ-014 p  output  48  result.
REQ-015 carryout  output  4  per-lane carry/borrow.

Function
REQ-016 X mux: 00 -> 0; 01 -> M; 11 -> {a,b} (48 bits); 10 -> P feedback.
REQ-017 Y mux: 00 -> 0; 01 -> M; 11 -> C; 10 -> all ones.
REQ-018 Z mux: 000 -> 0; 010 -> P feedback; 011 -> C; all other codes -> 0.
REQ-019 W mux: 00 -> 0; 01 -> P feedback; 11 -> C; 10 -> 0.
REQ-020 M is selected only when X = 01 and Y = 01 together; either 01 code alone contributes 0.
REQ-021 alumode 0000 -> Z+W+X+Y+CIN.
REQ-022 alumode 0011 -> Z-(W+X+Y+CIN).
REQ-023 alumode 0100 -> X xor Z.
REQ-024 alumode 1100 -> X and Z.
REQ-025 Any other alumode -> 0000 behaviour.
REQ-026 SIMD lanes add independently, with no carry crossing a lane boundary (bits 12/24/36 per mode).
REQ-027 Each lane wraps modulo 2^lanewidth.
REQ-028 carryout[i]: carry out of lane i for add, inverted borrow for subtract.
REQ-029 ONE48 drives carryout[3] only; TWO24 drives [1] and [3]; FOUR12 drives all four; undriven bits = 0.
REQ-030 Logic ops produce carryout = 0.
REQ-031 PREG=0: p and carryout are combinational from the inputs (0-cycle latency).
REQ-032 PREG=1: 1-cycle latency; p holds its value while cep = 0.
REQ-033 P feedback is the registered P when PREG=1 and 0 when PREG=0 (no combinational loop).
REQ-034 CREG=1 adds 1 cycle to the C path only; the C register updates when cec = 1.

Reset
REQ-035 Synchronous active-high reset clears the P, carryout and C registers to 0.
REQ-036 Reset takes priority over cep/cec.
REQ-037 With PREG=0, outputs stay combinational during reset.

Configuration
REQ-038 With macro DSP48E2_ALU_MULT_EN defined, M = signed a[26:0] x signed b[17:0], sign-extended to 48 bits.
REQ-039 Without DSP48E2_ALU_MULT_EN, M = 0 and no multiplier is synthesized.
REQ-040 With DSP48E2_ALU_MULT_EN defined, USE_SIMD must be "ONE48" whenever M is selected.

Structure
REQ-041 Shared package dsp48e2_alu_pkg holds the opmode field constants, the alumode encodings and the SIMD lane-width localparams.
REQ-042 One sub-module, dsp48e2_simd_adder (48-bit adder with lane-break carry chain and carryouts), instanced once.

Verification
REQ-043 TWO24, PREG=0, opmode 000110011, alumode 0000; a:b lanes 1/3, c lanes 2/4 -> p[23:0]=3, p[47:24]=7.
REQ-044 TWO24 add; lane0 24'hFFFFFF+1, lane1 5+5 -> p[23:0]=0, carryout[1]=1, p[47:24]=10.
REQ-045 ONE48, PREG=1, accumulate (Z=P, X=A:B) with a:b=1 for 4 cycles after reset -> p = 1,2,3,4; cep=0 freezes p; reset -> 0 next cycle.
REQ-046 alumode 0011, ONE48: c=10, a:b=3 -> p=7, carryout[3]=1.
REQ-047 Multiplier (macro defined): a=-3, b=5, opmode 000000101 -> p=48'hFFFFFFFFFFF1; same stimulus without the macro -> p=0.
